// File: rtl/hdpldadapt_cmn_async_launch_bus_pkg.sv
// Shared definitions for the asynchronous launch/capture bus crossing.
// The default hold window is also used to size the far-end capture stage.
package hdpldadapt_cmn_async_launch_bus_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } launch_state_e;

    localparam int DEFAULT_HOLD_CYCLES = 8;
    localparam int MAX_HOLD_CYCLES     = 255;

endpackage

// File: rtl/hdpldadapt_cmn_async_launch_bus_if.sv
// Handshake and bus signals between a word producer and the launcher.
interface hdpldadapt_cmn_async_launch_bus_if #(
    parameter int DWIDTH = 2
);
    logic [DWIDTH-1:0] data_in;
    logic              load;
    logic              ready;
    logic [DWIDTH-1:0] data_out;
    logic              stable;
    logic              load_drop;

    modport master (
        output data_in, load,
        input  ready, data_out, stable, load_drop
    );

    modport slave (
        input  data_in, load,
        output ready, data_out, stable, load_drop
    );
endinterface

// File: rtl/hdpldadapt_cmn_async_launch_bus.sv
// Launch-side register for a multi-bit bus crossing into an unrelated clock domain.
// Each accepted word is held unchanged for HOLD_CYCLES so the far end sees repeated identical samples.
module hdpldadapt_cmn_async_launch_bus
    import hdpldadapt_cmn_async_launch_bus_pkg::*;
#(
    parameter int DWIDTH      = 2,
    parameter bit RESET_VAL   = 1'b1,
    parameter int HOLD_CYCLES = DEFAULT_HOLD_CYCLES,
    parameter int CNT_WIDTH   = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic r_launch_mode,
    hdpldadapt_cmn_async_launch_bus_if.slave bus
);

    generate
        if (HOLD_CYCLES < 1 || HOLD_CYCLES > MAX_HOLD_CYCLES) begin : g_bad_hold
            $error("HOLD_CYCLES must be within 1..255");
        end
        if ((64'd1 << CNT_WIDTH) <= 64'(HOLD_CYCLES)) begin : g_bad_cnt
            $error("CNT_WIDTH too narrow for HOLD_CYCLES");
        end
    endgenerate

    localparam logic [CNT_WIDTH-1:0] CNT_LOAD = CNT_WIDTH'(HOLD_CYCLES - 1);
    localparam logic [DWIDTH-1:0]    DATA_RST = {DWIDTH{RESET_VAL}};

    launch_state_e         state_q, state_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
    logic [DWIDTH-1:0]     data_out_q, data_out_d;
    logic                  load_drop_q, load_drop_d;
    logic                  accept_d1_q, accept_d1_d;
    logic                  ready;
    logic                  accept;

    assign ready  = r_launch_mode | (state_q == ST_IDLE);
    assign accept = bus.load & ready;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        data_out_d  = data_out_q;
        load_drop_d = 1'b0;
        accept_d1_d = accept;
        if (r_launch_mode) begin
            // Pass-through: no hold protection, and any pending window is abandoned.
            state_d = ST_IDLE;
            cnt_d   = '0;
            if (accept) begin
                data_out_d = bus.data_in;
            end
        end else if (state_q == ST_IDLE) begin
            if (accept) begin
                data_out_d = bus.data_in;
                state_d    = ST_HOLD;
                cnt_d      = CNT_LOAD;
            end
        end else begin
            load_drop_d = bus.load;
            if (cnt_q == '0) begin
                state_d = ST_IDLE;
            end else begin
                cnt_d = cnt_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            data_out_q  <= DATA_RST;
            load_drop_q <= 1'b0;
            accept_d1_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            data_out_q  <= data_out_d;
            load_drop_q <= load_drop_d;
            accept_d1_q <= accept_d1_d;
        end
    end

    // data_out must come straight from flops: the far domain samples it asynchronously.
    assign bus.data_out  = data_out_q;
    assign bus.ready     = ready;
    assign bus.stable    = (state_q == ST_IDLE) & ~accept_d1_q;
    assign bus.load_drop = load_drop_q;

endmodule
